// File: rtl/brus16_loader_pkg.sv
// Shared types and constants for the bsram byte-stream program loader.
package brus16_loader_pkg;

    // Frame parser states; StCsum is only reachable when LOADER_CHECKSUM_EN is defined.
    typedef enum logic [2:0] {
        StIdle,
        StLenHi,
        StLenLo,
        StDataHi,
        StDataLo,
        StCsum
    } loader_state_t;

    // Start-of-frame marker; only recognised while idle.
    localparam logic [7:0] LOADER_MAGIC = 8'hB5;

endpackage

// File: rtl/bsram_loader.sv
// Byte-stream program loader driving a 16-bit bsram write port.
// Frame: MAGIC | LEN_HI | LEN_LO | {W_HI, W_LO} x LEN | [CSUM].
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// covering LEN_HI, LEN_LO and all data bytes.
module bsram_loader
    import brus16_loader_pkg::*;
#(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned SIZE  = 8192,
    parameter int unsigned BASE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             we,
    output logic [WIDTH-1:0] mem_din_addr,
    output logic [15:0]      mem_din,
    output logic             cpu_hold,
    output logic             done,
    output logic             err
);

    // Largest LEN that still fits between BASE and the end of the RAM.
    localparam logic [31:0] MAX_LEN = 32'(SIZE - BASE);

    loader_state_t    r_state;
    logic [15:0]      r_len;
    logic [15:0]      r_index;
    logic [7:0]       r_hi;
    logic             r_we;
    logic [WIDTH-1:0] r_addr;
    logic [15:0]      r_din;
    logic             r_hold;
    logic             r_done;
    logic             r_err;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]       r_csum;
`endif

    logic             w_hs;
    logic [15:0]      w_len;
    logic [WIDTH-1:0] w_addr;
    logic             w_last;

    // Loader never needs backpressure: one write per two bytes.
    assign in_ready = ~rst;
    assign w_hs     = in_valid & in_ready;
    assign w_len    = {r_len[15:8], in_data};
    assign w_addr   = WIDTH'(BASE + 32'(r_index));
    assign w_last   = (r_index == r_len - 16'd1);

    assign we           = r_we;
    assign mem_din_addr = r_addr;
    assign mem_din      = r_din;
    assign cpu_hold     = r_hold;
    assign done         = r_done;
    assign err          = r_err;

    // Frame parser FSM with registered write port and status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_len   <= '0;
            r_index <= '0;
            r_hi    <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
            r_hold  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_csum  <= '0;
`endif
        end else begin
            r_we <= 1'b0;
            if (w_hs) begin
                case (r_state)
                    StIdle: begin
                        // Non-magic bytes are consumed and dropped.
                        if (in_data == LOADER_MAGIC) begin
                            r_state <= StLenHi;
                            r_hold  <= 1'b1;
                            r_done  <= 1'b0;
                            r_err   <= 1'b0;
                            r_index <= '0;
                        end
                    end
                    StLenHi: begin
                        r_len[15:8] <= in_data;
`ifdef LOADER_CHECKSUM_EN
                        r_csum      <= in_data;
`endif
                        r_state     <= StLenLo;
                    end
                    StLenLo: begin
                        r_len[7:0] <= in_data;
`ifdef LOADER_CHECKSUM_EN
                        r_csum     <= r_csum ^ in_data;
`endif
                        if ({16'd0, w_len} > MAX_LEN) begin
                            // Oversized image: keep the CPU held until a good load.
                            r_state <= StIdle;
                            r_err   <= 1'b1;
                        end else if (w_len == 16'd0) begin
`ifdef LOADER_CHECKSUM_EN
                            r_state <= StCsum;
`else
                            r_state <= StIdle;
                            r_done  <= 1'b1;
                            r_hold  <= 1'b0;
`endif
                        end else begin
                            r_state <= StDataHi;
                        end
                    end
                    StDataHi: begin
                        r_hi    <= in_data;
`ifdef LOADER_CHECKSUM_EN
                        r_csum  <= r_csum ^ in_data;
`endif
                        r_state <= StDataLo;
                    end
                    StDataLo: begin
                        r_we    <= 1'b1;
                        r_din   <= {r_hi, in_data};
                        r_addr  <= w_addr;
                        r_index <= r_index + 16'd1;
`ifdef LOADER_CHECKSUM_EN
                        r_csum  <= r_csum ^ in_data;
`endif
                        if (w_last) begin
`ifdef LOADER_CHECKSUM_EN
                            r_state <= StCsum;
`else
                            r_state <= StIdle;
                            r_done  <= 1'b1;
                            r_hold  <= 1'b0;
`endif
                        end else begin
                            r_state <= StDataHi;
                        end
                    end
`ifdef LOADER_CHECKSUM_EN
                    StCsum: begin
                        // Written words are kept even on a checksum failure.
                        r_state <= StIdle;
                        if (in_data == r_csum) begin
                            r_done <= 1'b1;
                            r_hold <= 1'b0;
                        end else begin
                            r_err  <= 1'b1;
                        end
                    end
`endif
                    default: r_state <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bsram_loader.sv
// Scoreboard bench for bsram_loader: expected writes are queued as frames are
// sent; a negedge monitor pops and compares every we pulse.
module tb_bsram_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        we;
    logic [12:0] mem_din_addr;
    logic [15:0] mem_din;
    logic        cpu_hold;
    logic        done;
    logic        err;

    typedef struct packed {
        logic [12:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] tx_q[$];
    int         n_checks = 0;
    int         n_errs   = 0;
    logic       prev_we  = 1'b0;

    always #5 clk = ~clk;

    bsram_loader #(
        .WIDTH(13),
        .SIZE (8192),
        .BASE (0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .we          (we),
        .mem_din_addr(mem_din_addr),
        .mem_din     (mem_din),
        .cpu_hold    (cpu_hold),
        .done        (done),
        .err         (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errs++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: every write pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (we === 1'b1) begin
            check("we_single_cycle", {31'd0, prev_we}, 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL unexpected_write: got addr %0h data %0h want none",
                         mem_din_addr, mem_din);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", {19'd0, mem_din_addr}, {19'd0, e.addr});
                check("wr_data", {16'd0, mem_din}, {16'd0, e.data});
            end
        end
        prev_we = we;
    end

    // Present one byte for exactly one cycle after 'gap' idle cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = b;
        @(negedge clk);
        check("in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // gap_mode 0: back-to-back; otherwise gap of (i % 6) cycles before byte i.
    task automatic send_all(input int gap_mode);
        for (int i = 0; i < tx_q.size(); i++) begin
            send_byte(tx_q[i], (gap_mode != 0) ? (i % 6) : 0);
        end
    endtask

    // XOR of every queued byte after the magic.
    function automatic logic [7:0] csum_of();
        logic [7:0] x = 8'h00;
        for (int i = 1; i < tx_q.size(); i++) x ^= tx_q[i];
        return x;
    endfunction

    task automatic add_csum(input logic [7:0] override, input bit use_override);
`ifdef LOADER_CHECKSUM_EN
        logic [7:0] c;
        c = use_override ? override : csum_of();
        tx_q.push_back(c);
`endif
    endtask

    task automatic check_status(input string tag, input logic d, input logic e, input logic h);
        @(negedge clk);
        check({tag, "_done"}, {31'd0, done}, {31'd0, d});
        check({tag, "_err"}, {31'd0, err}, {31'd0, e});
        check({tag, "_hold"}, {31'd0, cpu_hold}, {31'd0, h});
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd0);
        check("rst_we", {31'd0, we}, 32'd0);
        check("rst_addr", {19'd0, mem_din_addr}, 32'd0);
        check("rst_din", {16'd0, mem_din}, 32'd0);
        check("rst_status", {29'd0, cpu_hold, done, err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // 1: two-word frame.
        tx_q = '{8'hB5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
        add_csum(8'h00, 1'b0);
        exp_q.push_back('{addr: 13'd0, data: 16'h1234});
        exp_q.push_back('{addr: 13'd1, data: 16'hABCD});
        send_all(0);
        check_status("t1", 1'b1, 1'b0, 1'b0);
        drain("t1");

        // 2: empty frame; done must drop on magic and return at frame end.
        send_byte(8'hB5, 0);
        check_status("t2_mid", 1'b0, 1'b0, 1'b1);
        tx_q = '{8'hB5, 8'h00, 8'h00};
        add_csum(8'h00, 1'b0);
        tx_q.delete(0);
        send_all(0);
        check_status("t2", 1'b1, 1'b0, 1'b0);
        drain("t2");

        // 3: LEN = 0x2001 exceeds 8192, then a good frame recovers.
        tx_q = '{8'hB5, 8'h20, 8'h01};
        send_all(0);
        check_status("t3_rej", 1'b0, 1'b1, 1'b1);
        drain("t3_rej");
        tx_q = '{8'hB5, 8'h00, 8'h01, 8'hCA, 8'hFE};
        add_csum(8'h00, 1'b0);
        exp_q.push_back('{addr: 13'd0, data: 16'hCAFE});
        send_all(0);
        check_status("t3_ok", 1'b1, 1'b0, 1'b0);
        drain("t3_ok");

`ifdef LOADER_CHECKSUM_EN
        // 4: bad checksum keeps the written word but flags the frame.
        tx_q = '{8'hB5, 8'h00, 8'h01, 8'h00, 8'h07, 8'hFF};
        exp_q.push_back('{addr: 13'd0, data: 16'h0007});
        send_all(0);
        check_status("t4", 1'b0, 1'b1, 1'b1);
        drain("t4");
`endif

        // 5: reset mid-frame after the first word.
        tx_q = '{8'hB5, 8'h00, 8'h03, 8'h11, 8'h22, 8'h33};
        exp_q.push_back('{addr: 13'd0, data: 16'h1122});
        send_all(0);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t5_we", {31'd0, we}, 32'd0);
        check("t5_addr", {19'd0, mem_din_addr}, 32'd0);
        check("t5_din", {16'd0, mem_din}, 32'd0);
        check("t5_status", {29'd0, cpu_hold, done, err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drain("t5");

        // 6: idle garbage, then a frame carrying 0xB5 as data, with input gaps.
        tx_q = '{8'h00, 8'hFF, 8'h5A};
        send_all(1);
        check_status("t6_garbage", 1'b0, 1'b0, 1'b0);
        tx_q = '{8'hB5, 8'h00, 8'h03, 8'hB5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        add_csum(8'h00, 1'b0);
        exp_q.push_back('{addr: 13'd0, data: 16'hB501});
        exp_q.push_back('{addr: 13'd1, data: 16'h0203});
        exp_q.push_back('{addr: 13'd2, data: 16'h0405});
        send_all(1);
        check_status("t6", 1'b1, 1'b0, 1'b0);
        drain("t6");

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
